// File: rtl/pipelined_array_multiplier_if.sv
// Streaming handshake bundle for pipelined_array_multiplier.
// Tag sideband signals exist only when MULT_TAG_EN is defined.
interface pipelined_array_multiplier_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;
`ifdef MULT_TAG_EN
  logic [TAG_W-1:0]   in_tag;
  logic [TAG_W-1:0]   out_tag;
`endif

  modport master (
    output in_valid, a, b, signed_op, out_ready,
`ifdef MULT_TAG_EN
    output in_tag,
    input  out_tag,
`endif
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, signed_op, out_ready,
`ifdef MULT_TAG_EN
    input  in_tag,
    output out_tag,
`endif
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/pipelined_array_multiplier.sv
// Signed/unsigned array multiplier: input register plus STAGES partial-product slices,
// valid/ready handshake with global stall. Optional tag sideband: MULT_TAG_EN.
module pipelined_array_multiplier #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  pipelined_array_multiplier_if.slave mul
);
  localparam int unsigned R  = WIDTH / STAGES;
  localparam int unsigned PW = 2 * WIDTH;

  logic              advance;
  logic [STAGES:0]   v_q, v_d;
  logic [STAGES-1:0] sg_q, sg_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [PW-1:0]     sum_q [STAGES];
  logic [PW-1:0]     sum_d [STAGES];
  logic [PW-1:0]     sum_in [STAGES];
  logic [PW-1:0]     acc, bext, row;
  logic [WIDTH-1:0]  a_sh;

  always_comb begin
    advance   = ~v_q[STAGES] | mul.out_ready;
    v_d       = {v_q[STAGES-1:0], mul.in_valid};
    a_d[0]    = mul.a;
    b_d[0]    = mul.b;
    sg_d[0]   = mul.signed_op;
    sum_in[0] = '0;
    for (int s = 1; s < int'(STAGES); s++) begin
      a_d[s]    = a_q[s-1];
      b_d[s]    = b_q[s-1];
      sg_d[s]   = sg_q[s-1];
      sum_in[s] = sum_q[s-1];
    end
    acc  = '0;
    bext = '0;
    row  = '0;
    a_sh = '0;
    // Slice s adds rows s*R .. s*R+R-1; the MSB row carries negative weight when signed.
    for (int s = 0; s < int'(STAGES); s++) begin
      acc  = sum_in[s];
      bext = sg_q[s] ? {{WIDTH{b_q[s][WIDTH-1]}}, b_q[s]} : {{WIDTH{1'b0}}, b_q[s]};
      for (int r = 0; r < int'(R); r++) begin
        a_sh = a_q[s] >> (s * int'(R) + r);
        row  = a_sh[0] ? (bext << (s * int'(R) + r)) : '0;
        if (sg_q[s] && (s * int'(R) + r == int'(WIDTH) - 1)) begin
          acc = acc - row;
        end else begin
          acc = acc + row;
        end
      end
      sum_d[s] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      sg_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else if (advance) begin
      v_q  <= v_d;
      sg_q <= sg_d;
      for (int s = 0; s < int'(STAGES); s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
      end
    end
  end

  assign mul.in_ready  = advance;
  assign mul.out_valid = v_q[STAGES];
  assign mul.y         = sum_q[STAGES-1];

`ifdef MULT_TAG_EN
  // Index 0 is the input register; index s+1 follows slice s.
  logic [TAG_W-1:0] tag_q [STAGES+1];
  logic [TAG_W-1:0] tag_d [STAGES+1];

  always_comb begin
    tag_d[0] = mul.in_tag;
    for (int s = 1; s <= int'(STAGES); s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= int'(STAGES); s++) begin
        tag_q[s] <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s <= int'(STAGES); s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign mul.out_tag = tag_q[STAGES];
`endif
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench: 8-bit/2-stage DUT with scoreboard and directed corner cases,
// plus a 64-bit/4-stage DUT for the wide unsigned/signed products.
module tb_pipelined_array_multiplier;
  localparam int unsigned W   = 8;
  localparam int unsigned S   = 2;
  localparam int unsigned W64 = 64;
  localparam int unsigned S64 = 4;
  localparam int unsigned TW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_array_multiplier_if #(.WIDTH(W),   .TAG_W(TW)) b8  ();
  pipelined_array_multiplier_if #(.WIDTH(W64), .TAG_W(TW)) b64 ();

  pipelined_array_multiplier #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (b8.slave)
  );

  pipelined_array_multiplier #(.WIDTH(W64), .STAGES(S64), .TAG_W(TW)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (b64.slave)
  );

  typedef struct packed {
    logic [15:0]   y;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic [15:0] y;
  } vec_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int out_count = 0;
  int first_out = 0;
  int last_out = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: exact product of the operands in the selected interpretation.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic sg);
    int pa, pb;
    if (sg) begin
      pa = $signed(a);
      pb = $signed(b);
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    return 16'(pa * pb);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %0h expected none", b8.y);
      end else begin
        e = exp_q.pop_front();
        check("stream_y", b8.y, e.y);
`ifdef MULT_TAG_EN
        check("stream_tag", b8.out_tag, e.tag);
`endif
      end
      if (out_count == 0) first_out = cycle;
      last_out = cycle;
      out_count++;
    end
  end

  task automatic step_in(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic sg, input logic [TW-1:0] tag, output logic acc);
    b8.in_valid  = v;
    b8.a         = a;
    b8.b         = b;
    b8.signed_op = sg;
`ifdef MULT_TAG_EN
    b8.in_tag    = tag;
`endif
    @(negedge clk);
    acc = v && b8.in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back('{y: model(a, b, sg), tag: tag});
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      input logic [TW-1:0] tag);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step_in(1'b1, a, b, sg, tag, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
    b8.in_valid = 1'b0;
  endtask

  // Called at accept edge + #1; counts edges until out_valid, reported including accept edge.
  task automatic wait_latency(input string name);
    int n;
    n = 0;
    while (!b8.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n + 1, S + 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic acc;
    int acc_n;
    logic [127:0] e64;
    vecs[0] = '{a: 8'hFF, b: 8'hFF, sg: 1'b0, y: 16'hFE01};
    vecs[1] = '{a: 8'h00, b: 8'hAB, sg: 1'b0, y: 16'h0000};
    vecs[2] = '{a: 8'h80, b: 8'hFF, sg: 1'b1, y: 16'h0080};
    vecs[3] = '{a: 8'h7F, b: 8'h80, sg: 1'b1, y: 16'hC080};
    vecs[4] = '{a: 8'h80, b: 8'hFF, sg: 1'b0, y: 16'h7F80};

    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.signed_op = 1'b0; b8.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.signed_op = 1'b0; b64.out_ready = 1'b1;
`ifdef MULT_TAG_EN
    b8.in_tag = '0;
    b64.in_tag = '0;
`endif

    // Reset state
    #12;
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_y", b8.y, 0);
    check("rst_in_ready", b8.in_ready, 1);
    check("rst64_out_valid", b64.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: single operations with latency and value checks
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sg, 4'(i));
      wait_latency("tbl_latency");
      check("tbl_y", b8.y, vecs[i].y);
    end
    drain();

    // Mixed-mode back-to-back
    for (int i = 2; i < 5; i++) send(vecs[i].a, vecs[i].b, vecs[i].sg, 4'(i));
    drain();

    // Streaming: 20 random pairs on consecutive cycles
    out_count = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
    end
    drain();
    check("stream_count", out_count, 20);
    check("stream_consecutive", last_out - first_out, 19);

    // Backpressure: fill with out_ready low, then stall 5 cycles
    b8.out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      step_in(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), acc);
      if (acc) acc_n++;
    end
    check("bp_accepted", acc_n, S + 1);
    for (int i = 0; i < 5; i++) begin
      step_in(1'b1, 8'($urandom), 8'($urandom), 1'b0, 4'($urandom), acc);
      check("bp_in_ready", b8.in_ready, 0);
      check("bp_out_valid", b8.out_valid, 1);
      if (exp_q.size() != 0) begin
        check("bp_y_stable", b8.y, exp_q[0].y);
`ifdef MULT_TAG_EN
        check("bp_tag_stable", b8.out_tag, exp_q[0].tag);
`endif
      end
    end
    b8.in_valid = 1'b0;
    out_count = 0;
    b8.out_ready = 1'b1;
    drain();
    check("bp_drain_count", out_count, S + 1);

    // Reset mid-stream with three operations in flight
    for (int i = 0; i < 3; i++) begin
      step_in(1'b1, 8'($urandom) | 8'h01, 8'($urandom) | 8'h01, 1'b0, 4'h5, acc);
    end
    b8.in_valid = 1'b0;
    check("pre_rst_out_valid", b8.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", b8.out_valid, 0);
    check("async_rst_y", b8.y, 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(8'd3, 8'd5, 1'b0, 4'h3);
    wait_latency("post_rst_latency");
    check("post_rst_y", b8.y, 16'd15);
    drain();

    // Wide configuration: 64-bit, 4 stages
    for (int i = 0; i < 2; i++) begin
      int n;
      b64.in_valid  = 1'b1;
      b64.a         = '1;
      b64.b         = '1;
      b64.signed_op = 1'(i);
`ifdef MULT_TAG_EN
      b64.in_tag    = 4'hA;
`endif
      @(negedge clk);
      check("w64_in_ready", b64.in_ready, 1);
      @(posedge clk);
      #1;
      b64.in_valid = 1'b0;
      n = 0;
      while (!b64.out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("w64_latency", n + 1, S64 + 1);
      e64 = (i == 0) ? {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001} : 128'd1;
      check("w64_y", b64.y, e64);
`ifdef MULT_TAG_EN
      check("w64_tag", b64.out_tag, 4'hA);
`endif
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
